// File: rtl/ctrl_pipe_stage.sv
// ctrl_pipe_stage
//   Elastic pipeline register for a WIDTH-bit control bundle between
//   processor stages.  A main register plus a one-entry skid register
//   sustain one bundle per cycle.  in_ready depends only on registered
//   state, never combinationally on out_ready.  A synchronous flush
//   empties the stage, and a saturating counter records stalled cycles.
//
// Parameters
//   WIDTH      payload width (>= 1)
//   BUBBLE_VAL payload driven while the stage is empty or flushed
//   CNT_W      stall counter width (>= 1)
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   in_valid   upstream bundle present
//   in_ready   stage can accept (skid register empty)
//   in_data    upstream bundle
//   flush      synchronous kill of held and incoming bundles
//   out_valid  out_data holds a live bundle
//   out_ready  downstream accepts
//   out_data   bundle to downstream (BUBBLE_VAL when out_valid = 0)
//   cnt_clr    synchronous clear of stall_cnt
//   stall_cnt  saturating count of cycles with out_valid & !out_ready
module ctrl_pipe_stage #(
  parameter int unsigned           WIDTH      = 4,
  parameter logic [WIDTH-1:0]      BUBBLE_VAL = '0,
  parameter int unsigned           CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] stall_cnt
);

  // EMPTY: nothing held; ONE: main only; TWO: main and skid both full.
  // The (main empty, skid full) combination has no encoding at all.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    TWO   = 2'b11
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] main_d, main_nxt;
  logic [WIDTH-1:0] skid_d, skid_nxt;
  logic             main_v, skid_v;
  logic             accept, fire;

  assign main_v    = (state != EMPTY);
  assign skid_v    = (state == TWO);
  assign out_valid = main_v;
  assign out_data  = main_d;
  assign in_ready  = !skid_v;

  assign accept = in_valid & in_ready;
  assign fire   = out_valid & out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= EMPTY;
      main_d <= BUBBLE_VAL;
      skid_d <= BUBBLE_VAL;
    end else begin
      state  <= state_nxt;
      main_d <= main_nxt;
      skid_d <= skid_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    main_nxt  = main_d;
    skid_nxt  = skid_d;
    unique case (state)
      EMPTY: begin
        if (accept) begin
          state_nxt = ONE;
          main_nxt  = in_data;
        end
      end
      ONE: begin
        if (accept && fire) begin
          main_nxt = in_data;
        end else if (accept) begin
          state_nxt = TWO;
          skid_nxt  = in_data;
        end else if (fire) begin
          state_nxt = EMPTY;
          main_nxt  = BUBBLE_VAL;
        end
      end
      TWO: begin
        if (fire) begin
          state_nxt = ONE;
          main_nxt  = skid_d;
          skid_nxt  = BUBBLE_VAL;
        end
      end
      default: begin
        state_nxt = EMPTY;
        main_nxt  = BUBBLE_VAL;
        skid_nxt  = BUBBLE_VAL;
      end
    endcase
    // Flush overrides every transition; a fire this cycle has already been
    // seen downstream, so only held and incoming bundles are dropped.
    if (flush) begin
      state_nxt = EMPTY;
      main_nxt  = BUBBLE_VAL;
      skid_nxt  = BUBBLE_VAL;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ctrl_pipe_stage.sv
// tb_ctrl_pipe_stage
//   Bench for ctrl_pipe_stage.  Two instances share stimulus: the default
//   16-bit stall counter and a 3-bit one for saturation.  A queue model of
//   held bundles predicts every output after every clock edge.
module tb_ctrl_pipe_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [3:0]  in_data;
  logic        flush;
  logic        out_ready;
  logic        cnt_clr;

  logic        in_ready,   s_in_ready;
  logic        out_valid,  s_out_valid;
  logic [3:0]  out_data,   s_out_data;
  logic [15:0] stall_cnt;
  logic [2:0]  s_stall_cnt;

  always #5 clk = ~clk;

  ctrl_pipe_stage #(.WIDTH(4), .BUBBLE_VAL(4'h0), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .cnt_clr(cnt_clr), .stall_cnt(stall_cnt)
  );

  ctrl_pipe_stage #(.WIDTH(4), .BUBBLE_VAL(4'h0), .CNT_W(3)) u_sat (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
    .flush(flush),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
    .cnt_clr(cnt_clr), .stall_cnt(s_stall_cnt)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Reference model: bundles currently held, oldest first (capacity 2).
  logic [3:0]  mq[$];
  int unsigned m_cnt16 = 0;
  int unsigned m_cnt3  = 0;
  // Bundles observed leaving the DUT (out_valid & out_ready before an edge).
  logic [3:0]  seen[$];

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [3:0] exp_data;
    exp_data = (mq.size() != 0) ? mq[0] : 4'h0;
    check_eq("out_valid",   32'(out_valid),   32'(mq.size() != 0));
    check_eq("out_data",    32'(out_data),    32'(exp_data));
    check_eq("in_ready",    32'(in_ready),    32'(mq.size() < 2));
    check_eq("stall_cnt",   32'(stall_cnt),   m_cnt16);
    check_eq("s_out_valid", 32'(s_out_valid), 32'(mq.size() != 0));
    check_eq("s_out_data",  32'(s_out_data),  32'(exp_data));
    check_eq("s_stall_cnt", 32'(s_stall_cnt), m_cnt3);
  endtask

  // Drive one cycle of inputs, advance one edge, update the model, check.
  task automatic cycle(input logic iv, input logic [3:0] id, input logic ordy,
                       input logic fl, input logic clr);
    bit fire_m, accept_m, stall_m;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    cnt_clr   = clr;
    #1;
    if (out_valid && out_ready) seen.push_back(out_data);
    fire_m   = (mq.size() != 0) && ordy;
    accept_m = iv && (mq.size() < 2);
    stall_m  = (mq.size() != 0) && !ordy;
    @(posedge clk);
    #1;
    if (clr) begin
      m_cnt16 = 0;
      m_cnt3  = 0;
    end else if (stall_m) begin
      if (m_cnt16 < 65535) m_cnt16++;
      if (m_cnt3  < 7)     m_cnt3++;
    end
    if (fl) begin
      mq.delete();
    end else begin
      if (fire_m)   void'(mq.pop_front());
      if (accept_m) mq.push_back(id);
    end
    check_model();
  endtask

  task automatic model_reset();
    mq.delete();
    m_cnt16 = 0;
    m_cnt3  = 0;
  endtask

  initial begin
    int unsigned base;
    logic [3:0] exp_stream[6];

    // Reset held low with a bundle offered upstream.
    reset = 1'b0; in_valid = 1'b1; in_data = 4'hA;
    out_ready = 1'b0; flush = 1'b0; cnt_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_data",  32'(out_data),  32'd0);
    check_eq("rst_in_ready",  32'(in_ready),  32'd1);
    check_eq("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    model_reset();
    reset = 1'b1;
    cycle(1'b1, 4'hA, 1'b0, 1'b0, 1'b0);
    check_eq("first_data",  32'(out_data),  32'hA);
    check_eq("first_valid", 32'(out_valid), 32'd1);

    // Full-throughput stream 1..5.
    seen.delete();
    for (int i = 1; i <= 5; i++) begin
      cycle(1'b1, 4'(i), 1'b1, 1'b0, 1'b0);
      check_eq("stream_ready", 32'(in_ready), 32'd1);
      check_eq("stream_data",  32'(out_data), 32'(i));
    end
    cycle(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    exp_stream[0] = 4'hA;
    for (int i = 1; i <= 5; i++) exp_stream[i] = 4'(i);
    check_eq("stream_count", seen.size(), 32'd6);
    for (int i = 0; i < 6 && i < seen.size(); i++)
      check_eq("stream_order", 32'(seen[i]), 32'(exp_stream[i]));

    // Backpressure: 1 in main, 2 in skid, 3 held upstream.
    seen.delete();
    base = stall_cnt;
    cycle(1'b1, 4'h1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 4'h2, 1'b0, 1'b0, 1'b0);
    check_eq("bp_in_ready_low", 32'(in_ready), 32'd0);
    cycle(1'b1, 4'h3, 1'b0, 1'b0, 1'b0);
    check_eq("bp_hold_data",  32'(out_data),  32'h1);
    check_eq("bp_stall_cnt",  32'(stall_cnt), base + 2);
    cycle(1'b1, 4'h3, 1'b1, 1'b0, 1'b0);
    check_eq("bp_drain_ready", 32'(in_ready), 32'd1);
    cycle(1'b1, 4'h3, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    check_eq("bp_count", seen.size(), 32'd3);
    for (int i = 0; i < 3 && i < seen.size(); i++)
      check_eq("bp_order", 32'(seen[i]), 32'(i + 1));

    // Flush from TWO with a new bundle offered.
    seen.delete();
    cycle(1'b1, 4'h6, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 4'h7, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 4'h8, 1'b0, 1'b1, 1'b0);
    check_eq("flush_valid", 32'(out_valid), 32'd0);
    check_eq("flush_data",  32'(out_data),  32'd0);
    check_eq("flush_ready", 32'(in_ready),  32'd1);
    repeat (3) cycle(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    check_eq("flush_nothing_out", seen.size(), 32'd0);

    // Saturation of the 3-bit counter, then clear and resume.
    cycle(1'b1, 4'h9, 1'b0, 1'b0, 1'b1);
    repeat (10) cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    check_eq("sat_hold7", 32'(s_stall_cnt), 32'd7);
    cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    check_eq("sat_clr", 32'(s_stall_cnt), 32'd0);
    cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    check_eq("sat_resume", 32'(s_stall_cnt), 32'd1);
    cycle(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset in the middle of a cycle while holding bundles.
    cycle(1'b1, 4'h4, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 4'h5, 1'b0, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check_eq("async_valid", 32'(out_valid), 32'd0);
    check_eq("async_data",  32'(out_data),  32'd0);
    check_eq("async_ready", 32'(in_ready),  32'd1);
    check_eq("async_cnt",   32'(stall_cnt), 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    check_model();

    // Randomised traffic against the queue model.
    for (int i = 0; i < 10000; i++) begin
      cycle(($urandom % 4) != 0, 4'($urandom), ($urandom % 3) != 0,
            ($urandom % 32) == 0, ($urandom % 64) == 0);
      if (!out_valid) check_eq("rand_bubble", 32'(out_data), 32'd0);
      if (!out_valid) check_eq("rand_no_skid_alone", 32'(in_ready), 32'd1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe_stage.md
# ctrl_pipe_stage

Parametrised elastic pipeline register for control bundles between processor stages, e.g. ID/EX and EX/MEM control fields. It generalises the fixed-field control register into a WIDTH-bit payload with a valid/ready handshake. A two-entry skid buffer lets it take full throughput without a combinational ready path. It also provides a synchronous flush that inserts a bubble and a saturating stall-cycle counter for performance debug.

## Interface
- WIDTH, 4: payload width in bits (control bundle, e.g. RegWrite, MemWrite, ResultSrc[1:0]); must be ≥1
- BUBBLE_VAL, '0: payload value presented whenever the stage is empty or flushed
- CNT_W, 16: width of stall counter; must be ≥1
- clk  input  1  sole clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset; asserting (low) clears state immediately, release is synchronised externally
- in_valid  input  1  upstream has a bundle
- in_ready  output  1  stage can accept; driven directly from state, no combinational path from out_ready
- in_data  input  WIDTH  upstream bundle
- flush  input  1  synchronous kill of all held and incoming bundles
- out_valid  output  1  out_data holds a live bundle
- out_ready  input  1  downstream accepts
- out_data  output  WIDTH  bundle to downstream; equals BUBBLE_VAL when out_valid=0
- cnt_clr  input  1  synchronous clear of stall_cnt
- stall_cnt  output  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0

## Operation
- Storage: main register (main_v, main_d) and skid register (skid_v, skid_d).
- Handshakes: accept = in_valid & in_ready; fire = out_valid & out_ready.
- Outputs: out_valid = main_v; out_data = main_d; in_ready = !skid_v.
- States: EMPTY (main_v=0, skid_v=0), ONE (main_v=1, skid_v=0), TWO (main_v=1, skid_v=1). skid_v=1 with main_v=0 is illegal and must never occur.
- EMPTY transitions:
  - accept → ONE, main_d←in_data.
  - otherwise stay; main_d remains BUBBLE_VAL.
- ONE transitions:
  - accept & fire → ONE, main_d←in_data.
  - accept & !fire → TWO, skid_d←in_data.
  - !accept & fire → EMPTY, main_d←BUBBLE_VAL.
  - neither → hold.
- TWO transitions (in_ready=0, so no accept is possible):
  - fire → ONE, main_d←skid_d, skid_d←BUBBLE_VAL.
  - otherwise hold.
- Flush has highest priority over all transitions. Next state is EMPTY, with main_d and skid_d ← BUBBLE_VAL. Any bundle accepted in the flush cycle is discarded. A fire in the flush cycle still completes downstream, since it is a downstream-visible transfer of the current main_d.
- Ordering: bundles leave in acceptance order and none is lost or duplicated absent flush.
- stall_cnt update priority:
  - cnt_clr → 0.
  - else, when out_valid & !out_ready → +1, saturating at 2^CNT_W−1 (no wrap).
  - stall_cnt is not affected by flush.

## Timing
- Reset asserted (low), effective immediately and asynchronously:
  - main_v=0, skid_v=0, main_d=skid_d=BUBBLE_VAL, stall_cnt=0.
  - Resulting outputs: out_valid=0, out_data=BUBBLE_VAL, in_ready=1.
- Reset mid-transfer drops all held bundles. There is no partial state.
- Latency: a bundle accepted at edge k appears on out_data/out_valid after edge k, i.e. 1 cycle, when the stage was EMPTY or ONE-with-fire.
- Throughput: one bundle per cycle sustained while out_ready=1.
- Backpressure: one cycle after out_ready falls, at most one extra bundle is absorbed into skid. in_ready drops the cycle after the skid fills and rises the cycle after the skid drains.
- All outputs are register outputs except in_ready, which is a single inverter from skid_v.
- Flush at edge k: out_valid=0 and out_data=BUBBLE_VAL from edge k; in_ready=1 from edge k.

## Test plan
- Reset low with in_valid=1, in_data=4'hA → out_valid=0, out_data=BUBBLE_VAL=0, in_ready=1, stall_cnt=0. Release reset, same stimulus → out_data=4'hA, out_valid=1 after next edge.
- Stream 1,2,3,4,5 with out_ready=1 continuously → outputs 1..5 on consecutive cycles, 1-cycle latency, in_ready stays 1.
- Stream 1,2,3 with out_ready=0 from the cycle 1 is presented → 1 in main, 2 in skid, in_ready=0, 3 held upstream. Raise out_ready → outputs 1,2,3 in order, none lost or duplicated. stall_cnt increments once per stalled cycle.
- Stage in TWO (bundles 6,7) with flush=1 and in_valid=1, in_data=8 → next cycle out_valid=0, out_data=0, in_ready=1, and 6, 7 and 8 never appear.
- CNT_W=3, out_valid=1, out_ready=0 for 10 cycles → stall_cnt reaches 7 and holds. cnt_clr=1 for one cycle → 0, then resumes counting.
- Random valid/ready/flush for 10k cycles against a queue scoreboard → order preserved and no skid_v=1 with main_v=0. out_data==BUBBLE_VAL whenever out_valid=0.
